ratio_detector: RTL and testbench

Recovers the division ratio of a divided clock by counting `quick_clock` cycles between successive rising edges of `slow_clock`. It is the measuring counterpart of the prescaler: the prescaler produces `slow_clock` from `quick_clock`, and this block reports the ratio that was used. It sits in the `quick_clock` domain. It is used for bring-up checks, clock monitoring and loss-of-clock detection.

---
 rtl/ratio_detector_pkg.sv | 11 +
 rtl/ratio_detector_edge_sync.sv | 31 +++
 rtl/ratio_detector.sv | 125 ++++++++++++
 tb/tb_ratio_detector.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ratio_detector_pkg.sv
// Shared types and constants for the ratio detector.
package ratio_detector_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/ratio_detector_edge_sync.sv
// Brings slow_clock into the quick_clock domain and derives single-cycle
// rise/fall strobes from the synchronized level.
module edge_sync
  import ratio_detector_pkg::*;
(
  input  logic quick_clock,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   delay_q;

  always_ff @(posedge quick_clock) begin
    if (!reset_n) begin
      sync_q  <= '0;
      delay_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
      delay_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~delay_q;
  assign fall  = ~level & delay_q;

endmodule

// File: rtl/ratio_detector.sv
// Measures period and high time of slow_clock in quick_clock cycles, tracks
// lock on repeated equal periods and flags loss of slow_clock.
module ratio_detector
  import ratio_detector_pkg::*;
#(
  parameter int          WIDTH      = 32,
  parameter int unsigned TIMEOUT    = 1048576,
  parameter int          LOCK_COUNT = 4
) (
  input  logic             quick_clock,
  input  logic             reset_n,
  input  logic             slow_clock,
  output logic [WIDTH-1:0] ratio,
  output logic [WIDTH-1:0] high_time,
  output logic             ratio_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int                 MATCH_W  = $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0]   TERM_CNT = WIDTH'(TIMEOUT - 1);
  localparam logic [MATCH_W-1:0] LOCK_TGT = MATCH_W'(LOCK_COUNT);

  logic slow_level_unused;
  logic rise;
  logic fall;

  edge_sync u_edge_sync (
    .quick_clock (quick_clock),
    .reset_n     (reset_n),
    .din         (slow_clock),
    .level       (slow_level_unused),
    .rise        (rise),
    .fall        (fall)
  );

  state_e             state_q;
  logic [WIDTH-1:0]   cnt_q;
  logic [WIDTH-1:0]   hi_cap_q;
  logic [WIDTH-1:0]   ratio_q;
  logic [WIDTH-1:0]   high_time_q;
  logic               valid_q;
  logic               locked_q;
  logic               timeout_q;
  logic               have_prev_q;
  logic [MATCH_W-1:0] match_q;

  logic [WIDTH-1:0]   cnt_d;
  logic [WIDTH-1:0]   period_d;
  logic [MATCH_W-1:0] match_d;

  always_comb begin
    period_d = cnt_q + WIDTH'(1);

    // cnt parks at the terminal count so a lost clock cannot wrap it
    if (rise) begin
      cnt_d = '0;
    end else if (cnt_q == TERM_CNT) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = period_d;
    end

    if (have_prev_q && (period_d == ratio_q)) begin
      match_d = (match_q >= LOCK_TGT) ? LOCK_TGT : match_q + MATCH_W'(1);
    end else begin
      match_d = MATCH_W'(1);
    end
  end

  always_ff @(posedge quick_clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_cap_q    <= '0;
      ratio_q     <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
      have_prev_q <= 1'b0;
      match_q     <= '0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_q     <= MEASURE;
            have_prev_q <= 1'b0;
          end
        end
        MEASURE: begin
          if (fall) begin
            hi_cap_q <= period_d;
          end
          // A rise on the terminal-count cycle still completes the measurement
          if (rise) begin
            ratio_q     <= period_d;
            high_time_q <= hi_cap_q;
            valid_q     <= 1'b1;
            timeout_q   <= 1'b0;
            have_prev_q <= 1'b1;
            match_q     <= match_d;
            locked_q    <= (match_d >= LOCK_TGT);
          end else if (cnt_q == TERM_CNT) begin
            timeout_q   <= 1'b1;
            locked_q    <= 1'b0;
            match_q     <= '0;
            have_prev_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ratio       = ratio_q;
  assign high_time   = high_time_q;
  assign ratio_valid = valid_q;
  assign locked      = locked_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_ratio_detector.sv
// Directed bench: a prescaler-like slow_clock driver with a scoreboard of
// expected measurements popped on every ratio_valid pulse.
module tb_ratio_detector;

  localparam int          W  = 32;
  localparam int unsigned TO = 64;
  localparam int          LC = 4;

  logic         quick_clock = 1'b0;
  logic         reset_n     = 1'b0;
  logic         slow_clock  = 1'b0;
  logic [W-1:0] ratio;
  logic [W-1:0] high_time;
  logic         ratio_valid;
  logic         locked;
  logic         timeout;

  ratio_detector #(
    .WIDTH      (W),
    .TIMEOUT    (TO),
    .LOCK_COUNT (LC)
  ) dut (
    .quick_clock (quick_clock),
    .reset_n     (reset_n),
    .slow_clock  (slow_clock),
    .ratio       (ratio),
    .high_time   (high_time),
    .ratio_valid (ratio_valid),
    .locked      (locked),
    .timeout     (timeout)
  );

  always #5 quick_clock = ~quick_clock;

  typedef struct packed {
    logic [31:0] r;
    logic [31:0] h;
    logic        lk;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fails  = 0;

  bit armed;
  bit have_prev;
  int prev_p;
  int match;
  int last_h;
  int last_l;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    armed     = 1'b0;
    have_prev = 1'b0;
    match     = 0;
    prev_p    = 0;
  endtask

  // Called whenever a rising edge of slow_clock is driven
  task automatic model_rise();
    exp_t e;
    int   p;
    if (armed) begin
      p = last_h + last_l;
      if (have_prev && p == prev_p) match = (match >= LC) ? LC : match + 1;
      else match = 1;
      have_prev = 1'b1;
      prev_p    = p;
      e.r  = p;
      e.h  = last_h;
      e.lk = (match >= LC);
      exp_q.push_back(e);
    end else begin
      armed     = 1'b1;
      have_prev = 1'b0;
    end
  endtask

  task automatic period(input int h, input int l);
    slow_clock = 1'b1;
    model_rise();
    last_h = h;
    last_l = l;
    repeat (h) @(posedge quick_clock);
    #1 slow_clock = 1'b0;
    repeat (l) @(posedge quick_clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ratio"}, 64'(ratio), 64'(0));
    check({tag, "_high_time"}, 64'(high_time), 64'(0));
    check({tag, "_valid"}, 64'(ratio_valid), 64'(0));
    check({tag, "_locked"}, 64'(locked), 64'(0));
    check({tag, "_timeout"}, 64'(timeout), 64'(0));
  endtask

  always @(negedge quick_clock) begin
    if (reset_n && ratio_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 64'(ratio_valid), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_ratio", 64'(ratio), 64'(mon_e.r));
        check("pulse_high_time", 64'(high_time), 64'(mon_e.h));
        check("pulse_locked", 64'(locked), 64'(mon_e.lk));
        check("pulse_timeout", 64'(timeout), 64'(0));
        $display("pulse: ratio=%0d high_time=%0d locked=%0b", ratio, high_time, locked);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;
    int total;
    model_reset();
    last_h = 0;
    last_l = 0;

    // Reset state
    reset_n    = 1'b0;
    slow_clock = 1'b0;
    repeat (3) @(posedge quick_clock);
    #1 check_all_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(posedge quick_clock);
    #1;

    // Ratio 2: lock on the 4th pulse
    repeat (9) period(1, 1);

    // Ratio 10, then stop slow_clock
    repeat (6) period(5, 5);
    repeat (50) @(posedge quick_clock);
    #1 check("timeout_early", 64'(timeout), 64'(0));
    waited = 0;
    while (!timeout && waited < 30) begin
      @(posedge quick_clock);
      #1 waited++;
    end
    total = 10 + 50 + waited;
    check("timeout_set", 64'(timeout), 64'(1));
    check("timeout_window", 64'(total >= 64 && total <= 70), 64'(1));
    check("timeout_locked", 64'(locked), 64'(0));
    check("timeout_ratio_hold", 64'(ratio), 64'(10));
    check("timeout_high_hold", 64'(high_time), 64'(5));
    model_reset();

    // Restart at ratio 6: arming edge keeps timeout, next edge clears it
    period(3, 3);
    check("timeout_through_arm", 64'(timeout), 64'(1));
    repeat (5) period(3, 3);
    check("timeout_cleared", 64'(timeout), 64'(0));
    check("locked_ratio6", 64'(locked), 64'(1));

    // Locked at 8, one period of 9, then relock
    repeat (6) period(4, 4);
    period(4, 5);
    repeat (6) period(4, 4);
    check("relock", 64'(locked), 64'(1));

    // Reset for one cycle in the middle of a period
    slow_clock = 1'b1;
    model_rise();
    last_h = 4;
    last_l = 4;
    repeat (4) @(posedge quick_clock);
    #1 check("queue_drained_before_reset", 64'(exp_q.size()), 64'(0));
    reset_n = 1'b0;
    @(posedge quick_clock);
    #1 check_all_zero("midreset");
    reset_n    = 1'b1;
    slow_clock = 1'b0;
    model_reset();
    repeat (10) @(posedge quick_clock);
    #1;
    repeat (3) period(4, 4);

    // slow_clock high at reset release, duty 3 high / 7 low
    slow_clock = 1'b1;
    reset_n    = 1'b0;
    @(posedge quick_clock);
    #1 reset_n = 1'b1;
    model_reset();
    repeat (5) period(3, 7);
    check("duty_ratio", 64'(ratio), 64'(10));
    check("duty_high_time", 64'(high_time), 64'(3));

    repeat (10) @(posedge quick_clock);
    #1 check("queue_empty_end", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
